fft_frame_controller: RTL and testbench

Sequences the combinational N-point FFT core for one frame at a time.
- Collects a frame of real samples from a valid/ready stream into an input buffer.
- Holds the buffer stable on the core inputs for a fixed number of settle cycles, then captures the core's real/imag outputs.
- Streams the bins out in natural order over a valid/ready interface.
- Sits between the audio sample source and the spectrum consumer; the FFT core is instantiated beside it, not inside it.

---
 rtl/fft_frame_controller_pkg.sv | 16 +
 rtl/fft_frame_buffer.sv | 31 +++
 rtl/fft_frame_controller.sv | 135 +++++++++++++
 tb/tb_fft_frame_controller.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_frame_controller_pkg.sv
// Shared types and helpers for the FFT frame controller slice.
// Defines the controller state encoding and the counter/index width helper.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SETTLE = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    // At least one bit, so a depth or count of 1 still yields a legal vector.
    function automatic int index_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fft_frame_buffer.sv
// Register array of depth entries of width bits, exposed as one flat bus.
// Supports a single indexed write per cycle or a full parallel load.
module fft_frame_buffer
    import fft_ctrl_pkg::*;
#(
    parameter int depth = 32,
    parameter int width = 32,
    localparam int iw = index_width(depth)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [iw-1:0]          wr_index,
    input  logic [width-1:0]       wr_data,
    input  logic                   load_en,
    input  logic [depth*width-1:0] load_data,
    output logic [depth*width-1:0] data
);

    // A parallel load wins over an indexed write if both are requested.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (load_en) begin
            data <= load_data;
        end else if (wr_en) begin
            data[wr_index*width +: width] <= wr_data;
        end
    end

endmodule

// File: rtl/fft_frame_controller.sv
// Frame sequencer around an external combinational FFT core: fill a frame,
// hold it on the core for a settle window, capture the bins, stream them out.
module fft_frame_controller
    import fft_ctrl_pkg::*;
#(
    parameter int buffer_size   = 32,
    parameter int sample_size   = 32,
    parameter int settle_cycles = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [sample_size-1:0]             in_sample,
    output logic [buffer_size*sample_size-1:0] fft_input,
    input  logic [buffer_size*sample_size-1:0] fft_output_real,
    input  logic [buffer_size*sample_size-1:0] fft_output_imag,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [sample_size-1:0]             out_real,
    output logic [sample_size-1:0]             out_imag,
    output logic [$clog2(buffer_size)-1:0]     out_index,
    output logic                               out_last,
    output logic                               busy
);

    localparam int iw = index_width(buffer_size);
    localparam int sw = index_width(settle_cycles);
    localparam int ew = 2 * sample_size;
    localparam logic [iw-1:0] last_index = iw'(buffer_size - 1);
    localparam logic [sw-1:0] settle_last = sw'(settle_cycles - 1);

    state_t state;
    logic [iw-1:0] wr_cnt;
    logic [iw-1:0] rd_cnt;
    logic [sw-1:0] set_cnt;

    logic accept;
    logic handshake;
    logic capture;
    logic [buffer_size*sample_size-1:0] in_bus;
    logic [buffer_size*ew-1:0]          cap_bus;
    logic [buffer_size*ew-1:0]          out_bus;
    logic [ew-1:0]                      out_entry;

    assign in_ready  = (state == FILL) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DRAIN);
    assign handshake = out_valid && out_ready;
    assign capture   = (state == SETTLE) && (set_cnt == settle_last);
    assign busy      = (state != FILL);
    assign out_last  = out_valid && (rd_cnt == last_index);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FILL;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            set_cnt <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        if (wr_cnt == last_index) begin
                            wr_cnt  <= '0;
                            set_cnt <= '0;
                            state   <= SETTLE;
                        end else begin
                            wr_cnt <= wr_cnt + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    set_cnt <= set_cnt + 1'b1;
                    if (capture) begin
                        rd_cnt <= '0;
                        state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (handshake) begin
                        if (rd_cnt == last_index) begin
                            rd_cnt <= '0;
                            state  <= FILL;
                        end else begin
                            rd_cnt <= rd_cnt + 1'b1;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    fft_frame_buffer #(
        .depth (buffer_size),
        .width (sample_size)
    ) u_in_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (accept),
        .wr_index  (wr_cnt),
        .wr_data   (in_sample),
        .load_en   (1'b0),
        .load_data ('0),
        .data      (in_bus)
    );

    // Each output entry carries one bin as {imag, real}.
    for (genvar k = 0; k < buffer_size; k++) begin : g_pack
        assign cap_bus[k*ew +: ew] = {fft_output_imag[k*sample_size +: sample_size],
                                      fft_output_real[k*sample_size +: sample_size]};
    end

    fft_frame_buffer #(
        .depth (buffer_size),
        .width (ew)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (1'b0),
        .wr_index  ('0),
        .wr_data   ('0),
        .load_en   (capture),
        .load_data (cap_bus),
        .data      (out_bus)
    );

    assign fft_input = in_bus;
    assign out_entry = out_bus[rd_cnt*ew +: ew];
    assign out_real  = out_entry[sample_size-1:0];
    assign out_imag  = out_entry[ew-1:sample_size];
    assign out_index = rd_cnt;

endmodule

// File: tb/tb_fft_frame_controller.sv
// Directed bench for fft_frame_controller with an 8-point stub core
// (real[k] = in[k] + k + offset, imag[k] = -in[k]).
module tb_fft_frame_controller;

    localparam int N = 8;
    localparam int W = 32;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic in_ready;
    logic [W-1:0] in_sample;
    logic [N*W-1:0] fft_input;
    logic [N*W-1:0] fft_output_real;
    logic [N*W-1:0] fft_output_imag;
    logic out_valid;
    logic out_ready;
    logic [W-1:0] out_real;
    logic [W-1:0] out_imag;
    logic [2:0] out_index;
    logic out_last;
    logic busy;
    logic [W-1:0] stub_offset;

    int vectors = 0;
    int miscompares = 0;

    int f1[N] = '{10, 20, 30, 40, 50, 60, 70, 80};
    int f4[N] = '{5, -3, 100, 0, 7, -20, 1, 2};
    int f5[N] = '{1000, 2000, 3000, 4000, 5000, 6000, 7000, 8000};
    int f6[N] = '{-1, -2, -3, -4, -5, -6, -7, -8};

    always #5 clk = ~clk;

    fft_frame_controller #(
        .buffer_size   (N),
        .sample_size   (W),
        .settle_cycles (S)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_sample       (in_sample),
        .fft_input       (fft_input),
        .fft_output_real (fft_output_real),
        .fft_output_imag (fft_output_imag),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_real        (out_real),
        .out_imag        (out_imag),
        .out_index       (out_index),
        .out_last        (out_last),
        .busy            (busy)
    );

    // Stub core; stub_offset lets the bench disturb the outputs mid-settle.
    always_comb begin
        fft_output_real = '0;
        fft_output_imag = '0;
        for (int k = 0; k < N; k++) begin
            fft_output_real[k*W +: W] = fft_input[k*W +: W] + W'(k) + stub_offset;
            fft_output_imag[k*W +: W] = -fft_input[k*W +: W];
        end
    end

    function automatic logic [N*W-1:0] packFrame(input int s[N]);
        logic [N*W-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k*W +: W] = s[k];
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(observed), $signed(expected));
        end
    endtask

    task automatic checkBus(input string tag, input logic [N*W-1:0] observed,
                            input logic [N*W-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Feeds count samples; starts and ends on a falling edge.
    task automatic applyStimulus(input int s[N], input int count, input bit gaps);
        for (int k = 0; k < count; k++) begin
            if (gaps && (k % 2 == 1)) begin
                in_valid = 1'b0;
                @(negedge clk);
                checkOutput("gap_ready", in_ready, 1);
            end
            in_valid  = 1'b1;
            in_sample = s[k];
            for (int t = 0; t < 20 && !in_ready; t++) @(negedge clk);
            if (!in_ready) checkOutput("fill_timeout", in_ready, 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic checkSettle(input logic [N*W-1:0] expIn, input logic [W-1:0] junk,
                               input logic [W-1:0] finalOff);
        for (int i = 0; i < S; i++) begin
            checkOutput($sformatf("settle%0d_valid", i), out_valid, 0);
            checkOutput($sformatf("settle%0d_busy", i), busy, 1);
            checkOutput($sformatf("settle%0d_ready", i), in_ready, 0);
            checkBus($sformatf("settle%0d_input", i), fft_input, expIn);
            if (i == 1) stub_offset = junk;
            if (i == S - 1) stub_offset = finalOff;
            if (i < S - 1) @(negedge clk);
        end
    endtask

    task automatic drainFrame(input int s[N], input logic [W-1:0] off, input int stallBin,
                              input int stallCycles, input bit holdValid,
                              input int nextSample, input int stopAt);
        logic [W-1:0] expReal;
        logic [W-1:0] expImag;
        @(negedge clk);
        stub_offset = '0;
        in_valid  = holdValid;
        in_sample = nextSample;
        for (int k = 0; k < N; k++) begin
            expReal = s[k] + k + off;
            expImag = -s[k];
            checkOutput($sformatf("bin%0d_valid", k), out_valid, 1);
            checkOutput($sformatf("bin%0d_index", k), out_index, k);
            checkOutput($sformatf("bin%0d_real", k), out_real, expReal);
            checkOutput($sformatf("bin%0d_imag", k), out_imag, expImag);
            checkOutput($sformatf("bin%0d_last", k), out_last, (k == N - 1) ? 1 : 0);
            checkOutput($sformatf("bin%0d_busy", k), busy, 1);
            checkOutput($sformatf("bin%0d_ready", k), in_ready, 0);
            if (k == stopAt) return;
            if (k == stallBin) begin
                out_ready = 1'b0;
                for (int c = 0; c < stallCycles; c++) begin
                    @(negedge clk);
                    checkOutput($sformatf("stall%0d_valid", c), out_valid, 1);
                    checkOutput($sformatf("stall%0d_index", c), out_index, k);
                    checkOutput($sformatf("stall%0d_real", c), out_real, expReal);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
        end
        checkOutput("after_valid", out_valid, 0);
        checkOutput("after_ready", in_ready, 1);
        checkOutput("after_busy", busy, 0);
        checkOutput("after_last", out_last, 0);
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_sample   = '0;
        out_ready   = 1'b1;
        stub_offset = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_out_last", out_last, 0);
        checkOutput("rst_out_index", out_index, 0);
        checkOutput("rst_out_real", out_real, 0);
        checkOutput("rst_out_imag", out_imag, 0);
        checkBus("rst_fft_input", fft_input, '0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("release_ready", in_ready, 1);
        checkOutput("release_valid", out_valid, 0);

        $display("[TB] test 1: basic frame");
        applyStimulus(f1, N, 1'b0);
        checkSettle(packFrame(f1), '0, '0);
        drainFrame(f1, '0, -1, 0, 1'b0, 0, N);

        $display("[TB] test 2: input gaps");
        applyStimulus(f1, N, 1'b1);
        checkSettle(packFrame(f1), '0, '0);
        drainFrame(f1, '0, -1, 0, 1'b0, 0, N);

        $display("[TB] test 3: output backpressure at bin 2");
        applyStimulus(f1, N, 1'b0);
        checkSettle(packFrame(f1), '0, '0);
        drainFrame(f1, '0, 2, 3, 1'b0, 0, N);

        $display("[TB] test 4: core outputs change during settle");
        applyStimulus(f4, N, 1'b0);
        checkSettle(packFrame(f4), 32'd100, 32'd7);
        drainFrame(f4, 32'd7, -1, 0, 1'b0, 0, N);

        $display("[TB] test 5: reset mid-fill and mid-drain");
        applyStimulus(f1, 5, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstfill_in_ready", in_ready, 0);
        checkBus("rstfill_fft_input", fft_input, '0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstfill_release_ready", in_ready, 1);
        checkOutput("rstfill_release_valid", out_valid, 0);
        applyStimulus(f1, N, 1'b0);
        checkSettle(packFrame(f1), '0, '0);
        drainFrame(f1, '0, -1, 0, 1'b0, 0, 3);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstdrain_valid", out_valid, 0);
        checkOutput("rstdrain_busy", busy, 0);
        checkOutput("rstdrain_index", out_index, 0);
        checkOutput("rstdrain_real", out_real, 0);
        checkOutput("rstdrain_imag", out_imag, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rstdrain_release_ready", in_ready, 1);
        checkOutput("rstdrain_release_valid", out_valid, 0);
        applyStimulus(f5, N, 1'b0);
        checkSettle(packFrame(f5), '0, '0);
        drainFrame(f5, '0, -1, 0, 1'b0, 0, N);

        $display("[TB] test 6: back-to-back frames");
        applyStimulus(f1, N, 1'b0);
        checkSettle(packFrame(f1), '0, '0);
        drainFrame(f1, '0, -1, 0, 1'b1, f6[0], N);
        applyStimulus(f6, N, 1'b0);
        checkSettle(packFrame(f6), '0, '0);
        drainFrame(f6, '0, -1, 0, 1'b0, 0, N);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
